// File: rtl/cronometro_bcd.sv
// Seconds stopwatch (00..DEZ_MAX UNI_MAX, BCD) counting synchronized rising edges of a slow
// square wave, with start/stop, lap freeze, clear, direct 7-segment drive and a wrap pulse.
module cronometro_bcd #(
   parameter int unsigned DEZ_MAX         = 5,
   parameter int unsigned UNI_MAX         = 9,
   parameter bit          SEG_ATIVO_BAIXO = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       start_stop,
   input  logic       volta,
   input  logic       zera,
   output logic [3:0] unidade,
   output logic [3:0] dezena,
   output logic [6:0] seg_u,
   output logic [6:0] seg_d,
   output logic       rodando,
   output logic       estouro
);

   typedef enum logic [1:0] {PARADO, CONTANDO, VOLTA} estado_t;

   localparam logic [3:0] DEZ_LIM = 4'(DEZ_MAX);
   localparam logic [3:0] UNI_LIM = 4'(UNI_MAX);

   estado_t    estado_q, estado_d;
   logic       s1_q, s2_q, s3_q;
   logic [3:0] uni_q, uni_d, dez_q, dez_d;
   logic [3:0] lat_uni_q, lat_uni_d, lat_dez_q, lat_dez_d;
   logic       estouro_q, estouro_d;
   logic       rodando_q, rodando_d;
   logic       borda;
   logic       incrementa;

   assign borda = s2_q & ~s3_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         estado_q  <= PARADO;
         uni_q     <= 4'd0;
         dez_q     <= 4'd0;
         lat_uni_q <= 4'd0;
         lat_dez_q <= 4'd0;
         estouro_q <= 1'b0;
         rodando_q <= 1'b0;
      end else begin
         s1_q      <= tick_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         estado_q  <= estado_d;
         uni_q     <= uni_d;
         dez_q     <= dez_d;
         lat_uni_q <= lat_uni_d;
         lat_dez_q <= lat_dez_d;
         estouro_q <= estouro_d;
         rodando_q <= rodando_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      uni_d      = uni_q;
      dez_d      = dez_q;
      lat_uni_d  = lat_uni_q;
      lat_dez_d  = lat_dez_q;
      estouro_d  = 1'b0;
      incrementa = borda && (estado_q != PARADO);

      if (zera) begin
         estado_d = PARADO;
         uni_d    = 4'd0;
         dez_d    = 4'd0;
      end else begin
         // The increment uses the pre-edge state, so a stop in this cycle still counts the edge.
         if (incrementa) begin
            if (uni_q < UNI_LIM) begin
               uni_d = uni_q + 4'd1;
            end else begin
               uni_d = 4'd0;
               if (dez_q < DEZ_LIM) begin
                  dez_d = dez_q + 4'd1;
               end else begin
                  dez_d     = 4'd0;
                  estouro_d = 1'b1;
               end
            end
         end

         if (start_stop) begin
            estado_d = (estado_q == PARADO) ? CONTANDO : PARADO;
         end else if (volta) begin
            case (estado_q)
               CONTANDO: begin
                  estado_d  = VOLTA;
                  lat_uni_d = uni_q;
                  lat_dez_d = dez_q;
               end
               VOLTA:   estado_d = CONTANDO;
               default: estado_d = estado_q;
            endcase
         end
      end

      rodando_d = (estado_d != PARADO);
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] hi;
      case (d)
         4'd0:    hi = 7'h3F;
         4'd1:    hi = 7'h06;
         4'd2:    hi = 7'h5B;
         4'd3:    hi = 7'h4F;
         4'd4:    hi = 7'h66;
         4'd5:    hi = 7'h6D;
         4'd6:    hi = 7'h7D;
         4'd7:    hi = 7'h07;
         4'd8:    hi = 7'h7F;
         4'd9:    hi = 7'h6F;
         default: hi = 7'h00;
      endcase
      return SEG_ATIVO_BAIXO ? ~hi : hi;
   endfunction

   assign unidade = (estado_q == VOLTA) ? lat_uni_q : uni_q;
   assign dezena  = (estado_q == VOLTA) ? lat_dez_q : dez_q;
   assign seg_u   = seg7(unidade);
   assign seg_d   = seg7(dezena);
   assign rodando = rodando_q;
   assign estouro = estouro_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
// Bench for cronometro_bcd: per-cycle scoreboard against a seconds-based model, plus a
// table of control/tick scenarios with hand-derived display values and corner-case sequences.
module tb_cronometro_bcd;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick_in = 1'b0;
   logic       start_stop = 1'b0;
   logic       volta = 1'b0;
   logic       zera = 1'b0;
   logic [3:0] unidade, dezena;
   logic [6:0] seg_u, seg_d;
   logic       rodando, estouro;

   int checks = 0;
   int errors = 0;

   cronometro_bcd #(.DEZ_MAX(5), .UNI_MAX(9), .SEG_ATIVO_BAIXO(1'b1)) dut (
      .clock(clock), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
      .volta(volta), .zera(zera), .unidade(unidade), .dezena(dezena),
      .seg_u(seg_u), .seg_d(seg_d), .rodando(rodando), .estouro(estouro)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] uni;
      logic [3:0] dez;
      logic [6:0] segu;
      logic [6:0] segd;
      logic       rod;
      logic       est;
   } exp_t;

   exp_t sb_q[$];

   // Independent model: count kept as whole seconds 0..59
   logic m_s1 = 0, m_s2 = 0, m_s3 = 0;
   int   m_st = 0;            // 0 stopped, 1 counting, 2 lap
   int   m_sec = 0, m_lap = 0;
   logic m_est = 0, m_rod = 0;
   logic tick_lvl = 0;
   int   est_seen = 0;

   // Active-low 7-segment codes for 0..9
   logic [6:0] seg_al [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic model_step(input logic t, input logic ss, input logic vo, input logic ze, input logic rs);
      logic b;
      int   old;
      exp_t e;
      if (rs) begin
         m_s1 = 0; m_s2 = 0; m_s3 = 0; m_st = 0; m_sec = 0; m_lap = 0; m_est = 0;
      end else begin
         b     = m_s2 && !m_s3;
         old   = m_sec;
         m_est = 0;
         if (ze) begin
            m_st = 0; m_sec = 0;
         end else begin
            if (b && m_st != 0) begin
               if (m_sec == 59) begin m_sec = 0; m_est = 1; end
               else m_sec++;
            end
            if (ss) m_st = (m_st == 0) ? 1 : 0;
            else if (vo) begin
               if (m_st == 1) begin m_st = 2; m_lap = old; end
               else if (m_st == 2) m_st = 1;
            end
         end
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = t;
      end
      m_rod = (m_st != 0);
      old   = (m_st == 2) ? m_lap : m_sec;
      e.uni  = 4'(old % 10);
      e.dez  = 4'(old / 10);
      e.segu = seg_al[old % 10];
      e.segd = seg_al[old / 10];
      e.rod  = m_rod;
      e.est  = m_est;
      sb_q.push_back(e);
   endtask

   // One clock: drive at the falling edge, push expectation, compare after the next rising edge.
   task automatic cyc(input logic t, input logic ss, input logic vo, input logic ze, input logic rs);
      exp_t e, a;
      tick_in = t; start_stop = ss; volta = vo; zera = ze; reset = rs;
      tick_lvl = t;
      model_step(t, ss, vo, ze, rs);
      @(posedge clock);
      @(negedge clock);
      start_stop = 0; volta = 0; zera = 0;
      a = '{uni: unidade, dez: dezena, segu: seg_u, segd: seg_d, rod: rodando, est: estouro};
      if (estouro === 1'b1) est_seen++;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL sb_cycle: got u=%0d d=%0d su=%h sd=%h rod=%b est=%b expected u=%0d d=%0d su=%h sd=%h rod=%b est=%b",
                     a.uni, a.dez, a.segu, a.segd, a.rod, a.est, e.uni, e.dez, e.segu, e.segd, e.rod, e.est);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(tick_lvl, 0, 0, 0, 0);
   endtask

   task automatic rises(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      end
   endtask

   task automatic chk_disp(input string name, input logic [3:0] d, input logic [3:0] u,
                           input logic [6:0] sd, input logic [6:0] su, input logic rod);
      chk({name, "_dezena"}, 32'(dezena), 32'(d));
      chk({name, "_unidade"}, 32'(unidade), 32'(u));
      chk({name, "_seg_d"}, 32'(seg_d), 32'(sd));
      chk({name, "_seg_u"}, 32'(seg_u), 32'(su));
      chk({name, "_rodando"}, 32'(rodando), 32'(rod));
      $display("%s: display %0d%0d seg_d=%h seg_u=%h rodando=%b", name, dezena, unidade, seg_d, seg_u, rodando);
   endtask

   typedef struct {
      int         n_rises;
      logic       ss, vo, ze;
      logic [3:0] dez, uni;
      logic [6:0] segd, segu;
      logic       rod;
      string      name;
   } vec_t;

   vec_t tbl [9];

   task automatic apply_vec(input int i);
      if (tbl[i].ss || tbl[i].vo || tbl[i].ze) cyc(tick_lvl, tbl[i].ss, tbl[i].vo, tbl[i].ze, 0);
      rises(tbl[i].n_rises);
      idle(3);
      chk_disp(tbl[i].name, tbl[i].dez, tbl[i].uni, tbl[i].segd, tbl[i].segu, tbl[i].rod);
   endtask

   initial begin
      tbl[0] = '{3,  0, 1, 0, 4'd0, 4'd0, 7'h40, 7'h40, 1'b0, "volta_parado"};
      tbl[1] = '{5,  0, 0, 0, 4'd0, 4'd0, 7'h40, 7'h40, 1'b0, "no_start"};
      tbl[2] = '{11, 0, 0, 0, 4'd1, 4'd2, 7'h79, 7'h24, 1'b1, "count_12"};
      tbl[3] = '{47, 0, 0, 0, 4'd5, 4'd9, 7'h12, 7'h10, 1'b1, "count_59"};
      tbl[4] = '{7,  0, 0, 0, 4'd0, 4'd7, 7'h40, 7'h78, 1'b1, "count_07"};
      tbl[5] = '{4,  0, 1, 0, 4'd0, 4'd7, 7'h40, 7'h78, 1'b1, "lap_freeze"};
      tbl[6] = '{0,  0, 1, 0, 4'd1, 4'd1, 7'h79, 7'h79, 1'b1, "lap_release"};
      tbl[7] = '{22, 0, 0, 0, 4'd3, 4'd3, 7'h30, 7'h30, 1'b1, "count_33"};
      tbl[8] = '{42, 1, 0, 0, 4'd4, 4'd2, 7'h19, 7'h24, 1'b1, "count_42"};

      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk_disp("reset", 4'd0, 4'd0, 7'h40, 7'h40, 1'b0);
      chk("reset_estouro", 32'(estouro), 32'd0);

      for (int i = 0; i < 2; i++) apply_vec(i);

      // Start, then one rise: first change exactly three edges after tick_in goes high
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("latency_k", 32'(unidade), 32'd0);
      cyc(1, 0, 0, 0, 0);
      chk("latency_k1", 32'(unidade), 32'd0);
      cyc(0, 0, 0, 0, 0);
      chk("latency_k2", 32'(unidade), 32'd1);
      $display("latency: first increment visible after third edge, unidade=%0d", unidade);
      cyc(0, 0, 0, 0, 0);

      for (int i = 2; i < 4; i++) apply_vec(i);

      est_seen = 0;
      rises(1);
      idle(3);
      chk_disp("wrap", 4'd0, 4'd0, 7'h40, 7'h40, 1'b1);
      chk("wrap_estouro_cycles", 32'(est_seen), 32'd1);

      for (int i = 4; i < 8; i++) apply_vec(i);

      // zera and start_stop together: zera wins
      cyc(0, 1, 0, 1, 0);
      chk_disp("zera_ss", 4'd0, 4'd0, 7'h40, 7'h40, 1'b0);

      // zera coincident with a detected edge while counting
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      idle(2);
      chk_disp("zera_borda", 4'd0, 4'd0, 7'h40, 7'h40, 1'b0);

      apply_vec(8);

      // Reset pulse between edges has no effect
      #1 reset = 1'b1;
      #1 chk("async_pulse_uni", 32'(unidade), 32'd2);
      chk("async_pulse_dez", 32'(dezena), 32'd4);
      #1 reset = 1'b0;
      @(negedge clock);
      cyc(0, 0, 0, 0, 0);
      chk_disp("after_pulse", 4'd4, 4'd2, 7'h19, 7'h24, 1'b1);

      // Reset held: nothing until the next edge
      reset = 1'b1;
      #1 chk("reset_no_edge", 32'({dezena, unidade}), 32'h42);
      cyc(0, 0, 0, 0, 1);
      chk_disp("reset_mid", 4'd0, 4'd0, 7'h40, 7'h40, 1'b0);
      cyc(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/cronometro_bcd.md
Name: cronometro_bcd

Overview:
- Seconds stopwatch (00–59 BCD) that consumes the slow square wave produced by the clock divider (its MSB output) as its time base.
- Runs entirely on the fast system clock: synchronizes the slow wave, detects its rising edges and counts them under start/stop/lap/clear control.
- Drives two 7-segment digits directly and emits a wrap pulse for a future minutes stage.

Parameters:
- DEZ_MAX, 5, highest tens digit (tens counts 0..DEZ_MAX).
- UNI_MAX, 9, highest units digit (units counts 0..UNI_MAX).
- SEG_ATIVO_BAIXO, 1, 1 = segment outputs active-low (common anode); 0 = active-high.

Ports:
- clock, in, 1: system clock. All logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- tick_in, in, 1: slow square wave from the divider. Asynchronous to the counting logic; must be synchronized.
- start_stop, in, 1: single-cycle pulse, already debounced, in the clock domain.
- volta, in, 1: lap single-cycle pulse, already debounced.
- zera, in, 1: clear single-cycle pulse, already debounced.
- unidade, out, 4: displayed units BCD digit.
- dezena, out, 4: displayed tens BCD digit.
- seg_u, out, 7: units segments. Bit 0 = a … bit 6 = g.
- seg_d, out, 7: tens segments, same bit order.
- rodando, out, 1: 1 in CONTANDO or VOLTA.
- estouro, out, 1: one-cycle pulse when the count wraps from DEZ_MAX,UNI_MAX to 00.

Behaviour:
- Decided interface: one clock, `clock`; reset is synchronous and active-high, named `reset`.
- Reset (sampled at a clock edge):
  - count = 00, displayed digits = 00, state = PARADO.
  - Synchronizer flops s1, s2, s3 = 0; rodando = 0; estouro = 0.
  - seg_u / seg_d show "0": 7'h40 when SEG_ATIVO_BAIXO=1, 7'h3F otherwise.
  - Reset overrides every other input.
- Synchronizer and edge detect:
  - Each edge: s1<=tick_in, s2<=s1, s3<=s2.
  - borda = s2 & ~s3.
  - A tick_in rise before clock edge k becomes visible in the count after edge k+2 (3-edge latency).
  - Exactly one increment per tick_in rise, whatever the tick_in period.
- States: PARADO, CONTANDO, VOLTA.
  - PARADO: start_stop -> CONTANDO. volta is ignored.
  - CONTANDO: start_stop -> PARADO. volta -> VOLTA, freezing the current count into the display latch.
  - VOLTA: counting continues but the display stays frozen. volta -> CONTANDO (display live again). start_stop -> PARADO (display live again).
  - zera in any state -> PARADO, count = 00, display live.
- Input priority, highest first: reset > zera > start_stop > volta. When several pulses arrive in the same cycle, only the highest-priority one acts.
- Increment rule: at an edge where borda=1, zera=0 and the current (pre-edge) state is CONTANDO or VOLTA, the count increments. This also applies when start_stop leaves CONTANDO in that same cycle.
- Arithmetic:
  - If units < UNI_MAX, units+1.
  - Otherwise units = 0, and tens+1 if tens < DEZ_MAX.
  - Otherwise (DEZ_MAX,UNI_MAX) tens = 0 and estouro = 1 for exactly that one cycle.
  - estouro is registered: it is high in the cycle following the wrapping edge.
  - Digits never leave 0..9.
- Display:
  - unidade / dezena = live count in PARADO and CONTANDO, latched values in VOLTA.
  - seg_* are derived combinationally from unidade / dezena.
  - Active-high codes, digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Active-low codes are the bitwise inversion of the active-high codes.
- rodando is registered with the state: 1 from the edge that enters CONTANDO until the edge that enters PARADO.

Test Plan:
- Reset, then 5 tick_in rises with no start -> count stays 00; seg_u = 7'h40; rodando = 0.
- start_stop, then 12 tick_in rises -> dezena=1, unidade=2, seg_u=7'h24, seg_d=7'h79. First change appears exactly 3 clocks after the first tick_in rise.
- Run to 59, one more rise -> 00 and estouro high for exactly 1 cycle. Check at 59: seg_d=7'h12, seg_u=7'h10.
- At count 07, press volta, then 4 rises -> display holds 07. Press volta again -> display shows 11.
- zera and start_stop in the same cycle while CONTANDO at 33 -> 00 and PARADO. Then zera coincident with borda -> stays 00.
- reset asserted mid-count at 42 with no clock edge -> no change; at the next edge -> 00, PARADO. An asynchronous reset pulse between edges must have no effect.
